seg_scan_ctrl: RTL

Scan scheduler and frame-buffer controller for the 4-digit multiplexed seven-segment display on the AHB-Lite peripheral side. It takes a 16-bit hex value, per-digit decimal points, per-digit enables and a brightness level from the bus-side register block, double-buffers them, and time-multiplexes the digits with dead-time blanking and PWM dimming. New data reaches the active buffer only at frame boundaries, so the display never tears. It drives the `an`/`seg_led` pins in place of the bus slave's static digit select.

---
 rtl/seg_scan_ctrl_if.sv | 39 +++
 rtl/seg_scan_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl_if
//  Description : Connection bundle between the bus-side register block and
//                the seven-segment scan controller.
//                  disp_data  [15:0] nibble k is shown on digit k
//                  dp         [3:0]  decimal point per digit, 1 = lit
//                  digit_en   [3:0]  per-digit enable, 0 = digit dark
//                  bright     [3:0]  duty level 0..15
//                  load              one-cycle capture strobe
//                  load_ack          pulse when shadow goes active
//                  frame_tick        pulse after every frame boundary
//                  an         [3:0]  digit select, active-low
//                  seg_led    [7:0]  segments, active-high, bit 7 = dp
//                master : register-block side, slave : scan controller
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if;
    logic [15:0] disp_data;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic [3:0]  bright;
    logic        load;
    logic        load_ack;
    logic        frame_tick;
    logic [3:0]  an;
    logic [7:0]  seg_led;

    modport master (
        output disp_data, dp, digit_en, bright, load,
        input  load_ack, frame_tick, an, seg_led
    );

    modport slave (
        input  disp_data, dp, digit_en, bright, load,
        output load_ack, frame_tick, an, seg_led
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Scan scheduler and double-buffered frame controller for a
//                4-digit multiplexed seven-segment display. New data is
//                committed from the shadow to the active buffer only at a
//                frame boundary, digits are time-multiplexed with a blank
//                dead-time at the start of every slot, and the ON phase is
//                PWM-dimmed by the brightness level.
//  Ports       : HCLK   - clock
//                HRESET - synchronous active-high reset
//                bus    - seg_scan_ctrl_if.slave (data in, pins out)
//  Parameters  : SCAN_DIV  - clock cycles per digit slot
//                            (must be >= BLANK_CYC + 16)
//                BLANK_CYC - blank dead-time cycles per slot
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter logic [15:0] SCAN_DIV  = 16'h7000,
    parameter logic [15:0] BLANK_CYC = 16'd16
) (
    input  logic            HCLK,
    input  logic            HRESET,
    seg_scan_ctrl_if.slave  bus
);

    localparam logic [15:0] c_slot_last = SCAN_DIV - 16'd1;

    // Shadow (written by load) and active (displayed) buffers
    logic [15:0] r_sh_data;
    logic [3:0]  r_sh_dp;
    logic [3:0]  r_sh_en;
    logic [3:0]  r_sh_bright;
    logic [15:0] r_ac_data;
    logic [3:0]  r_ac_dp;
    logic [3:0]  r_ac_en;
    logic [3:0]  r_ac_bright;
    logic        r_pending;

    // Scan position
    logic [1:0]  r_digit;
    logic [15:0] r_cnt;

    // Registered pin / strobe outputs
    logic [3:0]  r_an;
    logic [7:0]  r_seg_led;
    logic        r_load_ack;
    logic        r_frame_tick;

    logic        w_slot_end;
    logic        w_boundary;
    logic [3:0]  w_nibble;
    logic        w_lit;
    logic [6:0]  w_hex;

    assign w_slot_end = (r_cnt == c_slot_last);
    assign w_boundary = w_slot_end && (r_digit == 2'd3);
    assign w_nibble   = r_ac_data[{r_digit, 2'b00} +: 4];

    // Lit only in the ON phase, when the digit is enabled and the low four
    // counter bits fall inside the PWM window; bright = 0 never lights.
    assign w_lit = r_ac_en[r_digit]
                && (r_cnt >= BLANK_CYC)
                && (r_cnt[3:0] < r_ac_bright);

    always_comb begin
        w_hex = 7'h00;
        case (w_nibble)
            4'h0: w_hex = 7'h3f;
            4'h1: w_hex = 7'h06;
            4'h2: w_hex = 7'h5b;
            4'h3: w_hex = 7'h4f;
            4'h4: w_hex = 7'h66;
            4'h5: w_hex = 7'h6d;
            4'h6: w_hex = 7'h7d;
            4'h7: w_hex = 7'h07;
            4'h8: w_hex = 7'h7f;
            4'h9: w_hex = 7'h6f;
            4'ha: w_hex = 7'h77;
            4'hb: w_hex = 7'h7c;
            4'hc: w_hex = 7'h39;
            4'hd: w_hex = 7'h5e;
            4'he: w_hex = 7'h79;
            4'hf: w_hex = 7'h71;
            default: w_hex = 7'h00;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sh_data    <= 16'h0000;
            r_sh_dp      <= 4'h0;
            r_sh_en      <= 4'h0;
            r_sh_bright  <= 4'h0;
            r_ac_data    <= 16'h0000;
            r_ac_dp      <= 4'h0;
            r_ac_en      <= 4'h0;
            r_ac_bright  <= 4'h0;
            r_pending    <= 1'b0;
            r_digit      <= 2'd0;
            r_cnt        <= 16'd0;
            r_an         <= 4'hF;
            r_seg_led    <= 8'h00;
            r_load_ack   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            // Slot / digit scan
            if (w_slot_end) begin
                r_cnt   <= 16'd0;
                r_digit <= r_digit + 2'd1;
            end else begin
                r_cnt   <= r_cnt + 16'd1;
            end

            // Commit takes the shadow as it was before this edge, so a load
            // landing on the boundary cycle is held for the next frame.
            if (w_boundary && r_pending) begin
                r_ac_data   <= r_sh_data;
                r_ac_dp     <= r_sh_dp;
                r_ac_en     <= r_sh_en;
                r_ac_bright <= r_sh_bright;
            end

            if (bus.load) begin
                r_sh_data   <= bus.disp_data;
                r_sh_dp     <= bus.dp;
                r_sh_en     <= bus.digit_en;
                r_sh_bright <= bus.bright;
                r_pending   <= 1'b1;
            end else if (w_boundary) begin
                r_pending   <= 1'b0;
            end

            r_load_ack   <= w_boundary && r_pending;
            r_frame_tick <= w_boundary;

            // an and seg_led come from the same state on the same edge
            if (w_lit) begin
                r_an      <= ~(4'b0001 << r_digit);
                r_seg_led <= {r_ac_dp[r_digit], w_hex};
            end else begin
                r_an      <= 4'hF;
                r_seg_led <= 8'h00;
            end
        end
    end

    assign bus.an         = r_an;
    assign bus.seg_led    = r_seg_led;
    assign bus.load_ack   = r_load_ack;
    assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire
